// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, ALU functions, branch conditions and CC layout.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_execute_pipe_if.sv
// Decode-to-execute and execute-to-memory signals of the execute stage.
interface y86_execute_pipe_if #(
  parameter int W  = 64,
  parameter int RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    icode;
  logic [3:0]    ifun;
  logic [W-1:0]  valA;
  logic [W-1:0]  valB;
  logic [W-1:0]  valC;
  logic [RW-1:0] dstE_in;
  logic [RW-1:0] dstM_in;
  logic          m_exc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    e_icode;
  logic          e_Cnd;
  logic [W-1:0]  e_valE;
  logic [W-1:0]  e_valA;
  logic [RW-1:0] e_dstE;
  logic [RW-1:0] e_dstM;
  logic [2:0]    cc;

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, dstE_in, dstM_in, m_exc, flush, out_ready,
    input  in_ready, out_valid, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, cc
  );

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, dstE_in, dstM_in, m_exc, flush, out_ready,
    output in_ready, out_valid, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, cc
  );
endinterface

// File: rtl/y86_cond_eval.sv
// Combinational Y86 condition evaluation from a {ZF,SF,OF} code; shared with fetch prediction.
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun_i,
  input  logic [2:0] cc_i,
  output logic       cnd_o
);

  logic zf, sf, of;

  assign zf = cc_i[CC_ZF];
  assign sf = cc_i[CC_SF];
  assign of = cc_i[CC_OF];

  always_comb begin
    case (ifun_i)
      C_YES:   cnd_o = 1'b1;
      C_LE:    cnd_o = (sf ^ of) | zf;
      C_L:     cnd_o = sf ^ of;
      C_E:     cnd_o = zf;
      C_NE:    cnd_o = ~zf;
      C_GE:    cnd_o = ~(sf ^ of);
      C_G:     cnd_o = ~(sf ^ of) & ~zf;
      default: cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_execute_pipe.sv
// Y86 execute stage: operand select, ALU, CC register and Cnd, behind a valid/ready result register.
module y86_execute_pipe
  import y86_pkg::*;
#(
  parameter int W  = 64,
  parameter int RW = 4
) (
  input logic               clk,
  input logic               reset,
  y86_execute_pipe_if.slave pipe
);

  logic          accept, cc_we, cond_cnd, cnd, fun_ok;
  logic          zf, sf, of;
  logic [W-1:0]  alu_a, alu_b, alu_r;
  alu_fun_e      fun;

  logic          out_valid_q, out_valid_d;
  logic [3:0]    e_icode_q, e_icode_d;
  logic          e_cnd_q, e_cnd_d;
  logic [W-1:0]  e_vale_q, e_vale_d;
  logic [W-1:0]  e_vala_q, e_vala_d;
  logic [RW-1:0] e_dste_q, e_dste_d;
  logic [RW-1:0] e_dstm_q, e_dstm_d;
  logic [2:0]    cc_q, cc_d;

  assign pipe.in_ready = ~out_valid_q | pipe.out_ready;
  assign accept        = pipe.in_valid & pipe.in_ready & ~pipe.flush;
  assign cc_we         = accept & (pipe.icode == ICODE_OPQ) & ~pipe.m_exc;

  always_comb begin
    case (pipe.icode)
      ICODE_CMOVXX, ICODE_OPQ:                   alu_a = pipe.valA;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:  alu_a = pipe.valC;
      ICODE_CALL, ICODE_PUSHQ:                   alu_a = {{(W-4){1'b1}}, 4'b1000};
      ICODE_RET, ICODE_POPQ:                     alu_a = W'(8);
      default:                                   alu_a = '0;
    endcase
  end

  always_comb begin
    case (pipe.icode)
      ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_OPQ, ICODE_CALL,
      ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:        alu_b = pipe.valB;
      default:                                   alu_b = '0;
    endcase
  end

  // NOTE: combinational blocks assign every output a default first so no path leaves a latch.
  always_comb begin
    fun    = ALU_ADD;
    fun_ok = 1'b1;
    if (pipe.icode == ICODE_OPQ) begin
      if (pipe.ifun > 4'd3) fun_ok = 1'b0;
      else                  fun = alu_fun_e'(pipe.ifun[1:0]);
    end

    alu_r = '0;
    of    = 1'b0;
    if (fun_ok) begin
      case (fun)
        ALU_ADD: begin
          alu_r = alu_b + alu_a;
          of    = (alu_a[W-1] == alu_b[W-1]) & (alu_r[W-1] != alu_a[W-1]);
        end
        ALU_SUB: begin
          alu_r = alu_b - alu_a;
          of    = (alu_a[W-1] != alu_b[W-1]) & (alu_r[W-1] != alu_b[W-1]);
        end
        ALU_AND: alu_r = alu_b & alu_a;
        ALU_XOR: alu_r = alu_b ^ alu_a;
        default: alu_r = '0;
      endcase
    end
    zf = (alu_r == '0);
    sf = alu_r[W-1];
  end

  // Cnd uses the registered CC, so an OPq accepted last cycle is already visible here.
  y86_cond_eval u_cond (
    .ifun_i (pipe.ifun),
    .cc_i   (cc_q),
    .cnd_o  (cond_cnd)
  );

  assign cnd = ((pipe.icode == ICODE_CMOVXX) || (pipe.icode == ICODE_JXX)) ? cond_cnd : 1'b1;

  always_comb begin
    out_valid_d = out_valid_q;
    e_icode_d   = e_icode_q;
    e_cnd_d     = e_cnd_q;
    e_vale_d    = e_vale_q;
    e_vala_d    = e_vala_q;
    e_dste_d    = e_dste_q;
    e_dstm_d    = e_dstm_q;
    cc_d        = cc_q;

    if (pipe.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      e_icode_d   = pipe.icode;
      e_cnd_d     = cnd;
      e_vale_d    = alu_r;
      e_vala_d    = pipe.valA;
      e_dste_d    = ((pipe.icode == ICODE_CMOVXX) && !cnd) ? RW'(RNONE) : pipe.dstE_in;
      e_dstm_d    = pipe.dstM_in;
    end else if (pipe.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (cc_we) cc_d = {zf, sf, of};
  end

  // NOTE: state registers use non-blocking assignments and an asynchronous reset, so reset
  // drops a held instruction immediately without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      e_icode_q   <= '0;
      e_cnd_q     <= 1'b0;
      e_vale_q    <= '0;
      e_vala_q    <= '0;
      e_dste_q    <= '0;
      e_dstm_q    <= '0;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      e_icode_q   <= e_icode_d;
      e_cnd_q     <= e_cnd_d;
      e_vale_q    <= e_vale_d;
      e_vala_q    <= e_vala_d;
      e_dste_q    <= e_dste_d;
      e_dstm_q    <= e_dstm_d;
      cc_q        <= cc_d;
    end
  end

  assign pipe.out_valid = out_valid_q;
  assign pipe.e_icode   = e_icode_q;
  assign pipe.e_Cnd     = e_cnd_q;
  assign pipe.e_valE    = e_vale_q;
  assign pipe.e_valA    = e_vala_q;
  assign pipe.e_dstE    = e_dste_q;
  assign pipe.e_dstM    = e_dstm_q;
  assign pipe.cc        = cc_q;

endmodule
